// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths and load-type encodings for the writeback stage
package wb_stage_pkg;

    localparam int BUS_64 = 64;
    localparam int BUS_32 = 32;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LD  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;
    localparam logic [2:0] LT_LWU = 3'b110;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - combinational load byte extraction and sign/zero extension
module wb_load_ext
    import wb_stage_pkg::*;
(
    input  logic [BUS_64-1:0] i_rdata,
    input  logic [2:0]        i_offset,
    input  logic [2:0]        i_load_type,
    output logic [BUS_64-1:0] o_data
);

    logic [BUS_64-1:0] w_shifted;

    // Misaligned offsets are not trapped; bytes shifted past bit 63 fill with zero.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_load_type)
            LT_LB:   o_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            LT_LH:   o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            LT_LW:   o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            LT_LBU:  o_data = {56'd0, w_shifted[7:0]};
            LT_LHU:  o_data = {48'd0, w_shifted[15:0]};
            LT_LWU:  o_data = {32'd0, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - single-entry writeback stage between memory and commit
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_memoryed_req,
    output logic              o_wb_memoryed_ack,
    input  logic [4:0]        i_wb_rd,
    input  logic              i_wb_rd_wen,
    input  logic [BUS_64-1:0] i_wb_rd_wdata,
    input  logic              i_wb_memread,
    input  logic [BUS_64-1:0] i_wb_mem_rdata,
    input  logic [2:0]        i_wb_mem_offset,
    input  logic [2:0]        i_wb_load_type,
    input  logic [BUS_64-1:0] i_wb_pc,
    input  logic [BUS_32-1:0] i_wb_inst,
    input  logic              i_wb_nocmt,
    input  logic              i_wb_skipcmt,
    output logic              o_wb_writebacked_req,
    input  logic              i_wb_writebacked_ack,
    output logic [4:0]        o_wb_rd,
    output logic              o_wb_rd_wen,
    output logic [BUS_64-1:0] o_wb_rd_wdata,
    output logic [BUS_64-1:0] o_wb_pc,
    output logic [BUS_32-1:0] o_wb_inst,
    output logic              o_wb_nocmt,
    output logic              o_wb_skipcmt
`ifdef WB_INSTRET_EN
    ,
    output logic [BUS_64-1:0] o_wb_instret
`endif
);

    logic              r_valid;
    logic [4:0]        r_rd;
    logic              r_rd_wen;
    logic [BUS_64-1:0] r_rd_wdata;
    logic [BUS_64-1:0] r_pc;
    logic [BUS_32-1:0] r_inst;
    logic              r_nocmt;
    logic              r_skipcmt;

    logic [BUS_64-1:0] w_load_data;
    logic              w_in_fire;
    logic              w_out_fire;

    wb_load_ext u_load_ext (
        .i_rdata     (i_wb_mem_rdata),
        .i_offset    (i_wb_mem_offset),
        .i_load_type (i_wb_load_type),
        .o_data      (w_load_data)
    );

    assign o_wb_memoryed_ack = !r_valid || i_wb_writebacked_ack;
    assign w_in_fire         = i_wb_memoryed_req && o_wb_memoryed_ack;
    assign w_out_fire        = r_valid && i_wb_writebacked_ack;

    // Load result is resolved at capture so the entry holds the final write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rd       <= '0;
            r_rd_wen   <= 1'b0;
            r_rd_wdata <= '0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_nocmt    <= 1'b0;
            r_skipcmt  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_valid    <= 1'b1;
                r_rd       <= i_wb_rd;
                r_rd_wen   <= i_wb_rd_wen;
                r_rd_wdata <= i_wb_memread ? w_load_data : i_wb_rd_wdata;
                r_pc       <= i_wb_pc;
                r_inst     <= i_wb_inst;
                r_nocmt    <= i_wb_nocmt;
                r_skipcmt  <= i_wb_skipcmt;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_wb_writebacked_req = r_valid;
    assign o_wb_rd_wen          = w_out_fire && r_rd_wen && (r_rd != 5'd0);
    assign o_wb_rd              = r_rd;
    assign o_wb_rd_wdata        = r_rd_wdata;
    assign o_wb_pc              = r_pc;
    assign o_wb_inst            = r_inst;
    assign o_wb_nocmt           = r_nocmt;
    assign o_wb_skipcmt         = r_skipcmt;

`ifdef WB_INSTRET_EN
    logic [BUS_64-1:0] r_instret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_out_fire && !r_nocmt) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign o_wb_instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage (vectors, corner sequences, random model)
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        i_wb_memoryed_req;
    logic        o_wb_memoryed_ack;
    logic [4:0]  i_wb_rd;
    logic        i_wb_rd_wen;
    logic [63:0] i_wb_rd_wdata;
    logic        i_wb_memread;
    logic [63:0] i_wb_mem_rdata;
    logic [2:0]  i_wb_mem_offset;
    logic [2:0]  i_wb_load_type;
    logic [63:0] i_wb_pc;
    logic [31:0] i_wb_inst;
    logic        i_wb_nocmt;
    logic        i_wb_skipcmt;
    logic        o_wb_writebacked_req;
    logic        i_wb_writebacked_ack;
    logic [4:0]  o_wb_rd;
    logic        o_wb_rd_wen;
    logic [63:0] o_wb_rd_wdata;
    logic [63:0] o_wb_pc;
    logic [31:0] o_wb_inst;
    logic        o_wb_nocmt;
    logic        o_wb_skipcmt;
`ifdef WB_INSTRET_EN
    logic [63:0] o_wb_instret;
`endif

    int total;
    int bad;

    wb_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_wb_memoryed_req    (i_wb_memoryed_req),
        .o_wb_memoryed_ack    (o_wb_memoryed_ack),
        .i_wb_rd              (i_wb_rd),
        .i_wb_rd_wen          (i_wb_rd_wen),
        .i_wb_rd_wdata        (i_wb_rd_wdata),
        .i_wb_memread         (i_wb_memread),
        .i_wb_mem_rdata       (i_wb_mem_rdata),
        .i_wb_mem_offset      (i_wb_mem_offset),
        .i_wb_load_type       (i_wb_load_type),
        .i_wb_pc              (i_wb_pc),
        .i_wb_inst            (i_wb_inst),
        .i_wb_nocmt           (i_wb_nocmt),
        .i_wb_skipcmt         (i_wb_skipcmt),
        .o_wb_writebacked_req (o_wb_writebacked_req),
        .i_wb_writebacked_ack (i_wb_writebacked_ack),
        .o_wb_rd              (o_wb_rd),
        .o_wb_rd_wen          (o_wb_rd_wen),
        .o_wb_rd_wdata        (o_wb_rd_wdata),
        .o_wb_pc              (o_wb_pc),
        .o_wb_inst            (o_wb_inst),
        .o_wb_nocmt           (o_wb_nocmt),
        .o_wb_skipcmt         (o_wb_skipcmt)
`ifdef WB_INSTRET_EN
        ,
        .o_wb_instret         (o_wb_instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  lt;
        logic [2:0]  off;
        logic [63:0] rdata;
        logic        memread;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] exp_data;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_wb_memoryed_req    = 1'b0;
        i_wb_rd              = '0;
        i_wb_rd_wen          = 1'b0;
        i_wb_rd_wdata        = '0;
        i_wb_memread         = 1'b0;
        i_wb_mem_rdata       = '0;
        i_wb_mem_offset      = '0;
        i_wb_load_type       = '0;
        i_wb_pc              = '0;
        i_wb_inst            = '0;
        i_wb_nocmt           = 1'b0;
        i_wb_skipcmt         = 1'b0;
        i_wb_writebacked_ack = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference load: pick bytes from a byte array, then extend from the top loaded byte.
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off, input int lt);
        logic [7:0]  b [8];
        logic [63:0] r;
        int          n;
        logic        sgn;
        for (int i = 0; i < 8; i++) b[i] = rdata[8*i +: 8];
        case (lt)
            0: begin n = 1; sgn = 1'b1; end
            1: begin n = 2; sgn = 1'b1; end
            2: begin n = 4; sgn = 1'b1; end
            4: begin n = 1; sgn = 1'b0; end
            5: begin n = 2; sgn = 1'b0; end
            6: begin n = 4; sgn = 1'b0; end
            default: begin n = 8; sgn = 1'b0; end
        endcase
        r = '0;
        for (int k = 0; k < n; k++)
            if (off + k < 8) r[8*k +: 8] = b[off + k];
        if (sgn && r[8*n-1])
            for (int k = n; k < 8; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic offer(input logic [4:0] rd, input logic wen, input logic [63:0] wdata,
                         input logic [63:0] pc, input logic nocmt);
        i_wb_memoryed_req = 1'b1;
        i_wb_rd           = rd;
        i_wb_rd_wen       = wen;
        i_wb_rd_wdata     = wdata;
        i_wb_memread      = 1'b0;
        i_wb_pc           = pc;
        i_wb_inst         = pc[31:0] ^ 32'h0000_0013;
        i_wb_nocmt        = nocmt;
    endtask

    // Random-phase model state
    logic        m_valid;
    logic [4:0]  m_rd;
    logic        m_wen;
    logic [63:0] m_data;
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic        m_nocmt;
    logic        m_skip;
    logic [63:0] m_instret;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();

        vecs[0]  = '{3'd0, 3'd3, 64'h0000_0000_8000_0000, 1'b1, 64'h0, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
        vecs[1]  = '{3'd6, 3'd4, 64'h8765_4321_0000_0000, 1'b1, 64'h0, 5'd2, 1'b1, 64'h0000_0000_8765_4321, 1'b1};
        vecs[2]  = '{3'd1, 3'd6, 64'h8001_0000_0000_0000, 1'b1, 64'h0, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b1};
        vecs[3]  = '{3'd5, 3'd7, 64'hAB00_0000_0000_0000, 1'b1, 64'h0, 5'd4, 1'b1, 64'h0000_0000_0000_00AB, 1'b1};
        vecs[4]  = '{3'd2, 3'd0, 64'h0000_0000_7FFF_FFFF, 1'b1, 64'h0, 5'd5, 1'b1, 64'h0000_0000_7FFF_FFFF, 1'b1};
        vecs[5]  = '{3'd2, 3'd1, 64'h0000_0080_0000_0000, 1'b1, 64'h0, 5'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[6]  = '{3'd3, 3'd0, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 5'd7, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[7]  = '{3'd7, 3'd2, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 5'd8, 1'b1, 64'h0000_0123_4567_89AB, 1'b1};
        vecs[8]  = '{3'd4, 3'd0, 64'h1122_3344_5566_77FF, 1'b1, 64'h0, 5'd9, 1'b1, 64'h0000_0000_0000_00FF, 1'b1};
        vecs[9]  = '{3'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hDEAD_BEEF, 5'd10, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b1};
        vecs[10] = '{3'd0, 3'd0, 64'h0, 1'b0, 64'h1234, 5'd0, 1'b1, 64'h0000_0000_0000_1234, 1'b0};
        vecs[11] = '{3'd0, 3'd0, 64'h0, 1'b0, 64'h5555, 5'd3, 1'b0, 64'h0000_0000_0000_5555, 1'b0};

        // Reset state
        #1;
        check("rst_req", o_wb_writebacked_req, 0);
        check("rst_wen", o_wb_rd_wen, 0);
        check("rst_pc", o_wb_pc, 0);
        check("rst_wdata", o_wb_rd_wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ack", o_wb_memoryed_ack, 1);

        // Table-driven load/extend vectors, one-cycle latency each
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            i_wb_memoryed_req    = 1'b1;
            i_wb_writebacked_ack = 1'b1;
            i_wb_load_type       = vecs[v].lt;
            i_wb_mem_offset      = vecs[v].off;
            i_wb_mem_rdata       = vecs[v].rdata;
            i_wb_memread         = vecs[v].memread;
            i_wb_rd_wdata        = vecs[v].wdata;
            i_wb_rd              = vecs[v].rd;
            i_wb_rd_wen          = vecs[v].rd_wen;
            i_wb_pc              = 64'(v) * 4;
            @(negedge clk);
            i_wb_memoryed_req = 1'b0;
            #1;
            check($sformatf("vec%0d_req", v), o_wb_writebacked_req, 1);
            check($sformatf("vec%0d_wdata", v), o_wb_rd_wdata, vecs[v].exp_data);
            check($sformatf("vec%0d_wen", v), o_wb_rd_wen, vecs[v].exp_wen);
            check($sformatf("vec%0d_pc", v), o_wb_pc, 64'(v) * 4);
        end
        @(negedge clk);
        #1;
        check("idle_req", o_wb_writebacked_req, 0);
        check("idle_wen", o_wb_rd_wen, 0);

        // Back-to-back with commit ack held high
        @(negedge clk);
        offer(5'd11, 1'b1, 64'hAAAA, 64'h100, 1'b0);
        @(negedge clk);
        offer(5'd12, 1'b1, 64'hBBBB, 64'h104, 1'b0);
        #1;
        check("b2b_in_ack", o_wb_memoryed_ack, 1);
        check("b2b_a_req", o_wb_writebacked_req, 1);
        check("b2b_a_wen", o_wb_rd_wen, 1);
        check("b2b_a_data", o_wb_rd_wdata, 64'hAAAA);
        @(negedge clk);
        i_wb_memoryed_req = 1'b0;
        #1;
        check("b2b_b_req", o_wb_writebacked_req, 1);
        check("b2b_b_wen", o_wb_rd_wen, 1);
        check("b2b_b_rd", o_wb_rd, 12);
        check("b2b_b_data", o_wb_rd_wdata, 64'hBBBB);
        @(negedge clk);
        #1;
        check("b2b_drained", o_wb_writebacked_req, 0);

        // Commit stalls for 3 cycles while upstream keeps offering
        @(negedge clk);
        offer(5'd13, 1'b1, 64'hC0DE, 64'h200, 1'b0);
        @(negedge clk);
        offer(5'd14, 1'b1, 64'hFFFF, 64'h204, 1'b0);
        i_wb_writebacked_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ack", c), o_wb_memoryed_ack, 0);
            check($sformatf("stall%0d_wen", c), o_wb_rd_wen, 0);
            check($sformatf("stall%0d_req", c), o_wb_writebacked_req, 1);
            check($sformatf("stall%0d_data", c), o_wb_rd_wdata, 64'hC0DE);
            @(negedge clk);
        end
        i_wb_memoryed_req    = 1'b0;
        i_wb_writebacked_ack = 1'b1;
        #1;
        check("stall_release_wen", o_wb_rd_wen, 1);
        check("stall_release_data", o_wb_rd_wdata, 64'hC0DE);
        check("stall_release_pc", o_wb_pc, 64'h200);
        @(negedge clk);
        #1;
        check("stall_after_req", o_wb_writebacked_req, 0);

        // Reset asserted while an entry is held
        @(negedge clk);
        offer(5'd15, 1'b1, 64'h7777, 64'h300, 1'b0);
        i_wb_writebacked_ack = 1'b0;
        @(negedge clk);
        i_wb_memoryed_req = 1'b0;
        #1;
        check("pre_rst_req", o_wb_writebacked_req, 1);
        i_wb_writebacked_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_req", o_wb_writebacked_req, 0);
        check("midrst_wen", o_wb_rd_wen, 0);
        check("midrst_pc", o_wb_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ack", o_wb_memoryed_ack, 1);
        check("midrst_release_req", o_wb_writebacked_req, 0);

`ifdef WB_INSTRET_EN
        do_reset();
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            offer(5'd1, 1'b1, 64'(h), 64'h400 + 64'(h), (h == 2));
        end
        @(negedge clk);
        i_wb_memoryed_req = 1'b0;
        @(negedge clk);
        #1;
        check("instret_five", o_wb_instret, 64'd4);
`endif

        // Randomized phase against the behavioural model
        do_reset();
        m_valid   = 1'b0;
        m_rd      = '0;
        m_wen     = 1'b0;
        m_data    = '0;
        m_pc      = '0;
        m_inst    = '0;
        m_nocmt   = 1'b0;
        m_skip    = 1'b0;
        m_instret = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            i_wb_memoryed_req    = ($urandom_range(0, 3) != 0);
            i_wb_writebacked_ack = ($urandom_range(0, 2) != 0);
            i_wb_rd              = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            i_wb_rd_wen          = 1'($urandom);
            i_wb_rd_wdata        = {$urandom, $urandom};
            i_wb_memread         = 1'($urandom);
            i_wb_mem_rdata       = {$urandom, $urandom};
            i_wb_mem_offset      = 3'($urandom);
            i_wb_load_type       = 3'($urandom);
            i_wb_pc              = {$urandom, $urandom};
            i_wb_inst            = $urandom;
            i_wb_nocmt           = ($urandom_range(0, 4) == 0);
            i_wb_skipcmt         = 1'($urandom);
            #1;
            check("rnd_in_ack", o_wb_memoryed_ack, !m_valid || i_wb_writebacked_ack);
            check("rnd_req", o_wb_writebacked_req, m_valid);
            check("rnd_wen", o_wb_rd_wen, m_valid && i_wb_writebacked_ack && m_wen && (m_rd != 0));
            if (m_valid) begin
                check("rnd_rd", o_wb_rd, m_rd);
                check("rnd_data", o_wb_rd_wdata, m_data);
                check("rnd_pc", o_wb_pc, m_pc);
                check("rnd_inst", o_wb_inst, m_inst);
                check("rnd_flags", {o_wb_nocmt, o_wb_skipcmt}, {m_nocmt, m_skip});
            end
`ifdef WB_INSTRET_EN
            check("rnd_instret", o_wb_instret, m_instret);
`endif
            @(posedge clk);
            if (m_valid && i_wb_writebacked_ack && !m_nocmt) m_instret++;
            if (i_wb_memoryed_req && (!m_valid || i_wb_writebacked_ack)) begin
                m_valid = 1'b1;
                m_rd    = i_wb_rd;
                m_wen   = i_wb_rd_wen;
                m_data  = i_wb_memread ? ref_load(i_wb_mem_rdata, int'(i_wb_mem_offset), int'(i_wb_load_type))
                                       : i_wb_rd_wdata;
                m_pc    = i_wb_pc;
                m_inst  = i_wb_inst;
                m_nocmt = i_wb_nocmt;
                m_skip  = i_wb_skipcmt;
            end else if (m_valid && i_wb_writebacked_ack) begin
                m_valid = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
